filter_switch_seq: RTL and testbench

- Sequences the front-end analog filter bank downstream of the frequency-band selector.
- Consumes the 3-bit band index from the selector and qualifies it for stability.
- Drives one-hot filter switch enables with break-before-make timing and mutes the DDS output until the new filter has settled.
- Prevents relay chatter on band-edge FREQW updates and prevents two filter paths from conducting at once.

---
 rtl/filter_switch_seq.sv | 144 ++++++++++++++
 tb/tb_filter_switch_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_switch_seq.sv
// Filter bank switch sequencer: qualifies the requested band index, then
// opens the old path, waits, closes the new path and holds the DDS mute
// until the new filter has settled.
module filter_switch_seq #(
  parameter int unsigned STABLE_CYC = 16,
  parameter int unsigned BREAK_CYC  = 200,
  parameter int unsigned SETTLE_CYC = 2000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] filter_select,
  output logic [7:0] filter_en,
  output logic [2:0] sel_active,
  output logic       mute,
  output logic       busy,
  output logic       switch_done
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned EN_W  = 8;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] BREAK_LAST  = CNT_W'(BREAK_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_BREAK  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [EN_W-1:0]  filter_en_q, filter_en_d;
  logic [SEL_W-1:0] sel_active_q, sel_active_d;
  logic             mute_q, mute_d;
  logic             busy_q, busy_d;
  logic             switch_done_q, switch_done_d;

  function automatic logic [EN_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = EN_W'(1) << idx;
  endfunction

  // State and output registers; reset starts the power-up switch to path 0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_BREAK;
      cnt_q         <= '0;
      cur_sel_q     <= '0;
      cand_q        <= '0;
      filter_en_q   <= '0;
      sel_active_q  <= '0;
      mute_q        <= 1'b1;
      busy_q        <= 1'b1;
      switch_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_sel_q     <= cur_sel_d;
      cand_q        <= cand_d;
      filter_en_q   <= filter_en_d;
      sel_active_q  <= sel_active_d;
      mute_q        <= mute_d;
      busy_q        <= busy_d;
      switch_done_q <= switch_done_d;
    end
  end

  // Next-state and next-output logic; one shared counter times every phase
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cur_sel_d     = cur_sel_q;
    cand_d        = cand_q;
    filter_en_d   = filter_en_q;
    sel_active_d  = sel_active_q;
    mute_d        = mute_q;
    switch_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        filter_en_d = onehot(cur_sel_q);
        mute_d      = 1'b0;
        if (filter_select != cur_sel_q) begin
          cand_d  = filter_select;
          cnt_d   = '0;
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (filter_select == cur_sel_q) begin
          state_d = ST_IDLE;
        end else if (filter_select != cand_q) begin
          cand_d = filter_select;
          cnt_d  = '0;
        end else if (cnt_q == STABLE_LAST) begin
          filter_en_d = '0;
          mute_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ST_BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        filter_en_d = '0;
        if (cnt_q == BREAK_LAST) begin
          cur_sel_d    = cand_q;
          sel_active_d = cand_q;
          filter_en_d  = onehot(cand_q);
          cnt_d        = '0;
          state_d      = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          mute_d        = 1'b0;
          switch_done_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BREAK;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign filter_en   = filter_en_q;
  assign sel_active  = sel_active_q;
  assign mute        = mute_q;
  assign busy        = busy_q;
  assign switch_done = switch_done_q;

endmodule

// File: tb/tb_filter_switch_seq.sv
// Bench for filter_switch_seq: directed scenarios plus random band requests,
// every cycle compared against a timeline model of the switch sequence.
module tb_filter_switch_seq;

  localparam int S = 4;
  localparam int B = 3;
  localparam int T = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] filter_select;
  logic [7:0] filter_en;
  logic [2:0] sel_active;
  logic       mute;
  logic       busy;
  logic       switch_done;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_sw counts edges since the break began (-1 when not switching),
  // m_qlen counts edges spent qualifying (-1 when not qualifying).
  int         m_sw   = 0;
  int         m_qlen = -1;
  logic [2:0] m_cur  = 3'd0;
  logic [2:0] m_tgt  = 3'd0;
  logic [2:0] m_cand = 3'd0;
  logic       m_done = 1'b0;

  logic saw_done;
  logic saw_80;

  filter_switch_seq #(
    .STABLE_CYC(S),
    .BREAK_CYC (B),
    .SETTLE_CYC(T),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .filter_select(filter_select),
    .filter_en    (filter_en),
    .sel_active   (sel_active),
    .mute         (mute),
    .busy         (busy),
    .switch_done  (switch_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [2:0] fs, input logic rn);
    m_done = 1'b0;
    if (!rn) begin
      m_sw = 0; m_qlen = -1; m_cur = 3'd0; m_tgt = 3'd0; m_cand = 3'd0;
    end else if (m_sw >= 0) begin
      m_sw++;
      if (m_sw == B) m_cur = m_tgt;
      if (m_sw == B + T) begin
        m_sw   = -1;
        m_done = 1'b1;
      end
    end else if (m_qlen < 0) begin
      if (fs != m_cur) begin
        m_cand = fs;
        m_qlen = 0;
      end
    end else if (fs == m_cur) begin
      m_qlen = -1;
    end else if (fs != m_cand) begin
      m_cand = fs;
      m_qlen = 0;
    end else if (m_qlen == S - 1) begin
      m_sw   = 0;
      m_tgt  = m_cand;
      m_qlen = -1;
    end else begin
      m_qlen++;
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge,
  // compare shortly after.
  task automatic step(input logic [2:0] fs, input logic rn);
    logic [7:0] exp_en;
    @(negedge clk);
    filter_select = fs;
    rst_n         = rn;
    @(posedge clk);
    model_edge(fs, rn);
    #1;
    exp_en = (m_sw >= 0 && m_sw < B) ? 8'h00 : (8'h01 << m_cur);
    chk("filter_en", 32'(filter_en), 32'(exp_en));
    chk("sel_active", 32'(sel_active), 32'(m_cur));
    chk("mute", 32'(mute), 32'(m_sw >= 0));
    chk("busy", 32'(busy), 32'(m_sw >= 0 || m_qlen >= 0));
    chk("switch_done", 32'(switch_done), 32'(m_done));
    chk("onehot0", 32'($countones(filter_en) <= 1), 32'd1);
    if (filter_en == 8'h00) chk("mute_when_open", 32'(mute), 32'd1);
    if (switch_done === 1'b1) saw_done = 1'b1;
    if (filter_en === 8'h80) saw_80 = 1'b1;
  endtask

  task automatic steps(input int n, input logic [2:0] fs);
    for (int i = 0; i < n; i++) step(fs, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    filter_select = 3'd0;
    saw_done      = 1'b0;
    saw_80        = 1'b0;

    // Power-up: reset, then release with band 0 requested
    step(3'd0, 1'b0);
    step(3'd0, 1'b0);
    chk("rst_en", 32'(filter_en), 32'h00);
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    steps(2, 3'd0);
    chk("pu_en_open", 32'(filter_en), 32'h00);
    step(3'd0, 1'b1);
    chk("pu_en_close", 32'(filter_en), 32'h01);
    chk("pu_mute_hold", 32'(mute), 32'd1);
    steps(4, 3'd0);
    chk("pu_mute_settle", 32'(mute), 32'd1);
    step(3'd0, 1'b1);
    chk("pu_done", 32'(switch_done), 32'd1);
    chk("pu_unmute", 32'(mute), 32'd0);
    step(3'd0, 1'b1);
    chk("pu_idle", 32'(busy), 32'd0);
    chk("pu_done_pulse", 32'(switch_done), 32'd0);

    // Step to band 5 and hold
    steps(5, 3'd5);
    chk("b5_open", 32'(filter_en), 32'h00);
    chk("b5_mute", 32'(mute), 32'd1);
    steps(3, 3'd5);
    chk("b5_close", 32'(filter_en), 32'h20);
    steps(5, 3'd5);
    chk("b5_done", 32'(switch_done), 32'd1);
    chk("b5_unmute", 32'(mute), 32'd0);
    chk("b5_sel", 32'(sel_active), 32'd5);
    steps(14, 3'd0);
    chk("back0_en", 32'(filter_en), 32'h01);
    chk("back0_idle", 32'(busy), 32'd0);

    // Two-cycle glitch to band 3 must not switch
    saw_done = 1'b0;
    steps(2, 3'd3);
    steps(6, 3'd0);
    chk("glitch_en", 32'(filter_en), 32'h01);
    chk("glitch_mute", 32'(mute), 32'd0);
    chk("glitch_no_done", 32'(saw_done), 32'd0);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Dither 2 then 4, hold 4
    steps(2, 3'd2);
    steps(4, 3'd4);
    chk("dith_still_closed", 32'(filter_en), 32'h01);
    step(3'd4, 1'b1);
    chk("dith_open", 32'(filter_en), 32'h00);
    steps(3, 3'd4);
    chk("dith_close", 32'(filter_en), 32'h10);
    steps(5, 3'd4);
    chk("dith_done", 32'(switch_done), 32'd1);
    chk("dith_sel", 32'(sel_active), 32'd4);

    // Request 6 while settling a switch to 1
    steps(8, 3'd1);
    chk("s1_close", 32'(filter_en), 32'h02);
    steps(5, 3'd6);
    chk("s1_done", 32'(switch_done), 32'd1);
    chk("s1_sel", 32'(sel_active), 32'd1);
    step(3'd6, 1'b1);
    chk("s6_qual_busy", 32'(busy), 32'd1);
    chk("s6_qual_en", 32'(filter_en), 32'h02);
    steps(4, 3'd6);
    chk("s6_open", 32'(filter_en), 32'h00);
    steps(3, 3'd6);
    chk("s6_close", 32'(filter_en), 32'h40);
    steps(5, 3'd6);
    chk("s6_done", 32'(switch_done), 32'd1);
    chk("s6_sel", 32'(sel_active), 32'd6);

    // Reset in the middle of the break towards band 7
    steps(6, 3'd7);
    chk("b7_break", 32'(filter_en), 32'h00);
    saw_80 = 1'b0;
    step(3'd7, 1'b0);
    chk("mid_rst_en", 32'(filter_en), 32'h00);
    chk("mid_rst_mute", 32'(mute), 32'd1);
    chk("mid_rst_sel", 32'(sel_active), 32'd0);
    steps(3, 3'd0);
    chk("rep_close", 32'(filter_en), 32'h01);
    steps(5, 3'd0);
    chk("rep_done", 32'(switch_done), 32'd1);
    steps(2, 3'd0);
    chk("rep_no_80", 32'(saw_80), 32'd0);
    chk("rep_idle", 32'(busy), 32'd0);

    // Random band requests with random hold times and occasional resets
    for (int k = 0; k < 120; k++) begin
      logic [2:0] fs;
      int         hold;
      fs   = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 39) == 0) step(fs, 1'b0);
      for (int j = 0; j < hold; j++) step(fs, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
